signed_bcd_display: RTL and testbench
=====================================

Name: signed_bcd_display

Overview:
- Downstream consumer of the two's-complement negation stage in the turkey-counter datapath.
- Takes a signed 8-bit count and derives its magnitude by two's complement when negative.
- Converts the magnitude to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Time-multiplexes sign plus three digits onto a 4-digit common-anode 7-segment display.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit before the anode scan advances (minimum 2).
- CNT_W, 17: width of the refresh divider counter; must satisfy 2^CNT_W > REFRESH_DIV.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  sampled on a rising clk edge; when idle, launches a conversion of value_in.
- value_in  in  8  signed two's-complement count, range -128..127.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when new digits are latched for display.
- an  out  4  anode enables, active-low; an[3] is leftmost (sign), an[0] is ones.
- seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset: busy=0, done=0, an=4'b1111, seg=7'b1111111. Display registers clear to sign=0 and BCD 000. Scan index = 0, refresh counter = 0, FSM in IDLE.
- Reset mid-conversion aborts the conversion. Display registers clear; no done pulse is issued.
- FSM states: IDLE, SHIFT, LATCH.
- IDLE with start=1 at edge N:
  - Capture sign = value_in[7].
  - Capture mag = (sign ? ~value_in + 1 : value_in) as 8-bit unsigned. -128 yields 8'h80 = 128.
  - Clear the 12-bit BCD scratch; busy=1 after edge N; go to SHIFT.
- SHIFT: on each of edges N+1..N+8, add 3 to any BCD nibble >= 5, then shift {bcd, mag} left by one. After the 8th shift, go to LATCH.
- LATCH, at edge N+9:
  - Copy sign and BCD into the display registers.
  - done=1 for the cycle after N+9 only; busy=0 after N+9.
  - Return to IDLE.
- Conversion latency: start sampled to done asserted is 9 cycles. The earliest next start is accepted at edge N+10.
- start while busy (SHIFT or LATCH) is ignored, not queued. value_in is only sampled at the accepting edge.
- Display registers hold their value between conversions; the display never shows partial results.
- Refresh divider:
  - The counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - an and seg are registered and update on the wrap edge, so the first lit digit appears REFRESH_DIV cycles after reset.
- Exactly one an bit is low after the first wrap. Scan index 3 drives an=4'b0111 … index 0 drives an=4'b1110.
- Digit content by index:
  - 3 = '-' (7'b0111111) if sign is set, else blank (7'b1111111).
  - 2 = hundreds, 1 = tens, 0 = ones.
- Digit encodings (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - BCD values above 9 are unreachable; they display as blank.
- The scan runs continuously and independently of the conversion FSM. A done during a scan period takes effect at the next wrap edge.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - The hundreds digit is blank when hundreds == 0.
  - The tens digit is blank when hundreds == 0 and tens == 0.
  - The ones digit is always shown.
  - The sign digit is unaffected.
- Undefined: all three numeric digits are always shown, zeros included.
- FSM timing and handshake are identical in both builds.

Test Plan:
- Reset, REFRESH_DIV=4, no start → an=1111 and seg=1111111 during the first 4 cycles. Then digits 3..0 show blank,0,0,0; with LEADING_ZERO_BLANK_EN they show blank,blank,blank,0.
- value_in=8'hFB (-5), start pulse → busy high for 9 cycles, done pulse at cycle 9 after the start edge. Scan shows 0111111, 1000000, 1000000, 0010010 (blank,blank replacing the two zeros under LEADING_ZERO_BLANK_EN).
- value_in=8'h80 (-128) → digits '-',1,2,8 = 0111111, 1111001, 0100100, 0000000.
- value_in=8'h7F (127) → digits blank,1,2,7 = 1111111, 1111001, 0100100, 1111000.
- Convert 127, then pulse start with value_in=8'h00 at cycles 3 and 6 of busy → both ignored; one done only; display stays 127. A start at cycle 10 with value_in=0 then displays 000.
- Display 127, then start with -5 and assert rst at cycle 4 of SHIFT → immediate an=1111, busy=0, no done. After release the display shows 000.

Source files
------------

// File: rtl/signed_bcd_display.sv
// signed_bcd_display: signed 8-bit count to sign + 3 BCD digits on a
// 4-digit multiplexed common-anode 7-segment display.
// The magnitude is taken by two's complement, then converted with a
// sequential shift-add-3 (double-dabble) FSM: IDLE -> SHIFT x8 -> LATCH.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits
// (hundreds, and tens when hundreds is also zero); ones always shown.
module signed_bcd_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] value_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] an,
   output logic [6:0] seg
);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   state_t           state;
   logic             sign_r;
   logic [7:0]       mag;
   logic [11:0]      bcd;
   logic [11:0]      bcd_adj;
   logic [2:0]       shift_cnt;
   logic             disp_sign;
   logic [11:0]      disp_bcd;
   logic [CNT_W-1:0] ref_cnt;
   logic [1:0]       scan_idx;
   logic [1:0]       idx_next;
   logic [3:0]       an_next;
   logic [6:0]       seg_next;

   // BCD digit to active-low gfedcba pattern; out-of-range codes are blank
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   // Conversion FSM: capture magnitude, eight shift-add-3 steps, latch to display
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sign_r    <= 1'b0;
         mag       <= '0;
         bcd       <= '0;
         shift_cnt <= '0;
         disp_sign <= 1'b0;
         disp_bcd  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign_r    <= value_in[7];
                  mag       <= value_in[7] ? (~value_in + 8'd1) : value_in;
                  bcd       <= '0;
                  shift_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               bcd       <= {bcd_adj[10:0], mag[7]};
               mag       <= {mag[6:0], 1'b0};
               shift_cnt <= shift_cnt + 3'd1;
               if (shift_cnt == 3'd7)
                  state <= LATCH;
            end
            LATCH: begin
               disp_sign <= sign_r;
               disp_bcd  <= bcd;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Select anode and segment pattern for the digit the scan moves to next
   always_comb begin
      idx_next = scan_idx + 2'd1;
      an_next  = ~(4'b0001 << idx_next);
      seg_next = SEG_BLANK;
      case (idx_next)
         2'd3: seg_next = disp_sign ? SEG_MINUS : SEG_BLANK;
         2'd2: begin
            seg_next = seg7(disp_bcd[11:8]);
`ifdef LEADING_ZERO_BLANK_EN
            if (disp_bcd[11:8] == 4'd0)
               seg_next = SEG_BLANK;
`endif
         end
         2'd1: begin
            seg_next = seg7(disp_bcd[7:4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (disp_bcd[11:8] == 4'd0 && disp_bcd[7:4] == 4'd0)
               seg_next = SEG_BLANK;
`endif
         end
         default: seg_next = seg7(disp_bcd[3:0]);
      endcase
   end

   // Free-running refresh divider; an/seg are registered on the wrap edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt  <= '0;
         scan_idx <= '0;
         an       <= 4'b1111;
         seg      <= SEG_BLANK;
      end else if (ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         ref_cnt  <= '0;
         scan_idx <= idx_next;
         an       <= an_next;
         seg      <= seg_next;
      end else begin
         ref_cnt <= ref_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_signed_bcd_display.sv
// Self-checking bench for signed_bcd_display with a short refresh period.
// Expected digit patterns are queued when a conversion is launched and
// popped when done pulses; the scan is then checked against them.
module tb_signed_bcd_display;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] value_in;
   logic       busy;
   logic       done;
   logic [3:0] an;
   logic [6:0] seg;

   int          checks = 0;
   int          errors = 0;
   logic [27:0] sb[$];
   logic [27:0] cur_exp;

   signed_bcd_display #(.REFRESH_DIV(RD), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .value_in(value_in),
      .busy(busy), .done(done), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [6:0] dig(input int d);
      case (d)
         0: dig = 7'b1000000;  1: dig = 7'b1111001;
         2: dig = 7'b0100100;  3: dig = 7'b0110000;
         4: dig = 7'b0011001;  5: dig = 7'b0010010;
         6: dig = 7'b0000010;  7: dig = 7'b1111000;
         8: dig = 7'b0000000;  9: dig = 7'b0010000;
         default: dig = 7'b1111111;
      endcase
   endfunction

   // {pos3 sign, pos2 hundreds, pos1 tens, pos0 ones}
   function automatic logic [27:0] exp_disp(input int v);
      int m, h, t, o;
      logic [27:0] r;
      m = (v < 0) ? -v : v;
      h = m / 100;
      t = (m / 10) % 10;
      o = m % 10;
      r[27:21] = (v < 0) ? 7'b0111111 : 7'b1111111;
      r[20:14] = dig(h);
      r[13:7]  = dig(t);
      r[6:0]   = dig(o);
`ifdef LEADING_ZERO_BLANK_EN
      if (h == 0) r[20:14] = 7'b1111111;
      if (h == 0 && t == 0) r[13:7] = 7'b1111111;
`endif
      return r;
   endfunction

   task automatic pop_done(input string name);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s: done with empty scoreboard (got done=%b, required no done)", name, done);
      end else begin
         cur_exp = sb.pop_front();
      end
   endtask

   // Watch four full scan periods after the display has had a wrap to update
   task automatic check_scan(input string name);
      int pos, prev_pos;
      logic [3:0] seen;
      logic [6:0] e;
      prev_pos = -1;
      seen = 4'b0000;
      repeat (RD + 1) @(negedge clk);
      for (int i = 0; i < 4 * RD; i++) begin
         @(negedge clk);
         case (an)
            4'b1110: pos = 0;
            4'b1101: pos = 1;
            4'b1011: pos = 2;
            4'b0111: pos = 3;
            default: pos = -1;
         endcase
         checks++;
         if (pos < 0) begin
            errors++;
            $display("FAIL %s an: got %b, required one low bit", name, an);
         end else begin
            e = cur_exp[pos*7 +: 7];
            if (seg !== e) begin
               errors++;
               $display("FAIL %s seg pos%0d: got %b, required %b", name, pos, seg, e);
            end
            if (prev_pos >= 0 && pos != prev_pos) begin
               checks++;
               if (pos != (prev_pos + 1) % 4) begin
                  errors++;
                  $display("FAIL %s scan order: got pos%0d after pos%0d, required pos%0d",
                           name, pos, prev_pos, (prev_pos + 1) % 4);
               end
            end
            seen[pos] = 1'b1;
            prev_pos = pos;
         end
      end
      checks++;
      if (seen !== 4'b1111) begin
         errors++;
         $display("FAIL %s coverage: got digits %b, required 1111", name, seen);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; value_in = '0;
      cur_exp = exp_disp(0);
      #12;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < RD; i++) begin
         checks++;
         if ({an, seg, busy, done} !== {4'b1111, 7'b1111111, 2'b00}) begin
            errors++;
            $display("FAIL reset cycle%0d: got an=%b seg=%b busy=%b done=%b, required 1111 1111111 0 0",
                     i, an, seg, busy, done);
         end
         if (i < RD - 1) @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (an === 4'b1111) begin
         errors++;
         $display("FAIL reset first_lit: got an=%b, required a lit digit", an);
      end
      check_scan("reset_scan");
   endtask

   task automatic test_convert(input logic [7:0] v, input string name);
      @(negedge clk);
      value_in = v; start = 1'b1;
      sb.push_back(exp_disp(int'($signed(v))));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      value_in = 8'($urandom);
      for (int k = 0; k <= 8; k++) begin
         checks++;
         if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL %s busy cycle%0d: got busy=%b done=%b, required 1 0", name, k, busy, done);
         end
         @(negedge clk);
      end
      checks++;
      if ({busy, done} !== 2'b01) begin
         errors++;
         $display("FAIL %s done cycle9: got busy=%b done=%b, required 0 1", name, busy, done);
      end
      if (done === 1'b1) pop_done(name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s done width: got done=%b, required 0", name, done);
      end
      check_scan(name);
   endtask

   task automatic test_busy_ignore();
      int ndone, first_k, second_k;
      ndone = 0; first_k = -1; second_k = -1;
      @(negedge clk);
      value_in = 8'h7F; start = 1'b1;
      sb.push_back(exp_disp(127));
      @(posedge clk);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (ndone == 1) first_k = k;
            if (ndone == 2) second_k = k;
            pop_done("busy_ignore");
         end
         start = (k == 3 || k == 6 || k == 10);
         value_in = 8'h00;
         if (k == 10) sb.push_back(exp_disp(0));
      end
      start = 1'b0;
      checks++;
      if (first_k != 10) begin
         errors++;
         $display("FAIL busy_ignore first_done: got cycle %0d, required 10", first_k);
      end
      checks++;
      if (ndone != 2 || second_k != 20) begin
         errors++;
         $display("FAIL busy_ignore dones: got %0d (second at %0d), required 2 (second at 20)", ndone, second_k);
      end
      check_scan("busy_ignore_000");
   endtask

   task automatic test_reset_mid();
      bit saw;
      test_convert(8'h7F, "pre_reset_127");
      @(negedge clk);
      value_in = 8'hFB; start = 1'b1;
      sb.push_back(exp_disp(-5));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({an, seg, busy, done} !== {4'b1111, 7'b1111111, 2'b00}) begin
         errors++;
         $display("FAIL mid_reset: got an=%b seg=%b busy=%b done=%b, required 1111 1111111 0 0",
                  an, seg, busy, done);
      end
      sb.delete();
      cur_exp = exp_disp(0);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) saw = 1'b1;
      end
      checks++;
      if (saw) begin
         errors++;
         $display("FAIL mid_reset no_done: got done pulse, required none");
      end
      check_scan("mid_reset_000");
   endtask

   initial begin
      test_reset();
      test_convert(8'hFB, "neg5");
      test_convert(8'h80, "neg128");
      test_convert(8'h7F, "pos127");
      test_convert(8'h2A, "pos42");
      test_busy_ignore();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
